// File: rtl/fifo_byte_packer.sv
// Packs DATA_WIDTH-wide words read from a synchronous FIFO into PACK-wide little-endian beats.
// A flush closes the partially assembled word and marks it with m_last.
module fifo_byte_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fifo_rd_valid,
    output logic                       fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]      fifo_rd_data,
    input  logic                       flush,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [PACK*DATA_WIDTH-1:0] m_data,
    output logic [PACK-1:0]            m_keep,
    output logic                       m_last
);

    localparam int CW = $clog2(PACK) + 1;
    localparam int WW = PACK * DATA_WIDTH;
    localparam logic [CW-1:0] FULL = CW'(PACK);

    typedef enum logic [1:0] {FILL, DRAIN, EMIT} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            pend_q;
    logic [WW-1:0]   asm_q;
    logic            mValid_q;
    logic [WW-1:0]   mData_q;
    logic [PACK-1:0] mKeep_q;
    logic            mLast_q;

    logic [CW-1:0]   cnt_d;
    logic [WW-1:0]   asm_d;
    logic [PACK-1:0] partKeep;
    logic [WW-1:0]   partData;
    logic            outFree;

    // cnt_d/asm_d are the assembly contents after this cycle's in-flight byte lands.
    always_comb begin
        cnt_d    = cnt_q + {{(CW-1){1'b0}}, pend_q};
        asm_d    = asm_q;
        partKeep = '0;
        partData = '0;
        for (int i = 0; i < PACK; i++) begin
            if (pend_q && (cnt_q == CW'(i))) begin
                asm_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_rd_data;
            end
            partKeep[i] = (CW'(i) < cnt_q);
            if (partKeep[i]) begin
                partData[i*DATA_WIDTH +: DATA_WIDTH] = asm_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign outFree    = !mValid_q || m_ready;
    assign fifo_rd_en = rst_n && fifo_rd_valid && (state_q == FILL) && (cnt_d < FULL);

    // A flush in FILL defers any completion so the word closed by it carries m_last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FILL;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            asm_q    <= '0;
            mValid_q <= 1'b0;
            mData_q  <= '0;
            mKeep_q  <= '0;
            mLast_q  <= 1'b0;
        end else begin
            pend_q <= fifo_rd_en;
            if (mValid_q && m_ready) begin
                mValid_q <= 1'b0;
            end
            case (state_q)
                FILL: begin
                    asm_q <= asm_d;
                    if (flush) begin
                        cnt_q   <= cnt_d;
                        state_q <= DRAIN;
                    end else if ((cnt_d == FULL) && outFree) begin
                        cnt_q    <= '0;
                        mValid_q <= 1'b1;
                        mData_q  <= asm_d;
                        mKeep_q  <= '1;
                        mLast_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DRAIN: begin
                    asm_q <= asm_d;
                    cnt_q <= cnt_d;
                    if (!pend_q) begin
                        state_q <= (cnt_q != '0) ? EMIT : FILL;
                    end
                end
                EMIT: begin
                    if (outFree) begin
                        cnt_q    <= '0;
                        mValid_q <= 1'b1;
                        mData_q  <= partData;
                        mKeep_q  <= partKeep;
                        mLast_q  <= 1'b1;
                        state_q  <= FILL;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign m_valid = mValid_q;
    assign m_data  = mData_q;
    assign m_keep  = mKeep_q;
    assign m_last  = mLast_q;

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Directed bench for fifo_byte_packer: a FIFO model feeds bytes, expected beats go through a scoreboard queue.
module tb_fifo_byte_packer;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fifo_rd_valid;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data = 8'h00;
    logic        flush;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;

    logic [7:0] mem [0:255];
    int         wrPtr = 0;
    int         rdPtr = 0;
    beat_t      expQ [$];
    int         checks = 0;
    int         errors = 0;

    fifo_byte_packer #(.DATA_WIDTH(8), .PACK(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_rd_valid(fifo_rd_valid),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .flush        (flush),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_keep       (m_keep),
        .m_last       (m_last)
    );

    always #5 clk = ~clk;

    // Upstream FIFO model: data appears the cycle after a read handshake.
    assign fifo_rd_valid = (wrPtr != rdPtr);
    always @(posedge clk) begin
        if (fifo_rd_en && fifo_rd_valid) begin
            fifo_rd_data <= mem[rdPtr[7:0]];
            rdPtr        <= rdPtr + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        mem[wrPtr[7:0]] = b;
        wrPtr = wrPtr + 1;
    endtask

    task automatic pushExp(input logic [31:0] d, input logic [3:0] k, input logic l);
        beat_t e;
        e.data = d;
        e.keep = k;
        e.last = l;
        expQ.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulseFlush();
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        logic done;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            tick(1);
            done = (expQ.size() == 0) && (rdPtr == wrPtr) && !m_valid;
        end
        checkOutput(tag, {63'd0, done}, 64'd1);
    endtask

    task automatic waitFifoEmpty(input string tag);
        logic done;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            tick(1);
            done = (rdPtr == wrPtr);
        end
        checkOutput(tag, {63'd0, done}, 64'd1);
    endtask

    // Scoreboard side: every accepted beat must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("rdEnWithoutValid", {63'd0, fifo_rd_en && !fifo_rd_valid}, 64'd0);
            if (m_valid && m_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedBeat", {32'd0, m_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    beat_t e;
                    e = expQ.pop_front();
                    checkOutput("beatData", {32'd0, m_data}, {32'd0, e.data});
                    checkOutput("beatKeep", {60'd0, m_keep}, {60'd0, e.keep});
                    checkOutput("beatLast", {63'd0, m_last}, {63'd0, e.last});
                end
            end
        end
    end

    initial begin
        int n;
        rst_n   = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b1;
        tick(2);

        // Streaming with the FIFO preloaded while still in reset.
        for (int i = 1; i <= 8; i++) applyStimulus(8'(i));
        pushExp(32'h04030201, 4'hF, 1'b0);
        pushExp(32'h08070605, 4'hF, 1'b0);
        #1;
        checkOutput("resetRdEn", {63'd0, fifo_rd_en}, 64'd0);
        checkOutput("resetValid", {63'd0, m_valid}, 64'd0);
        checkOutput("resetData", {32'd0, m_data}, 64'd0);
        checkOutput("resetKeep", {60'd0, m_keep}, 64'd0);
        checkOutput("resetLast", {63'd0, m_last}, 64'd0);
        tick(1);
        rst_n = 1'b1;
        #1;
        checkOutput("firstRdEn", {63'd0, fifo_rd_en}, 64'd1);
        waitIdle("streamIdle");

        // Backpressure: nine bytes, two full words stall, ninth stays in the FIFO.
        m_ready = 1'b0;
        for (int i = 1; i <= 9; i++) applyStimulus(8'(8'h10 + i));
        pushExp(32'h14131211, 4'hF, 1'b0);
        pushExp(32'h18171615, 4'hF, 1'b0);
        pushExp(32'h00000019, 4'h1, 1'b1);
        tick(12);
        checkOutput("bpValid", {63'd0, m_valid}, 64'd1);
        checkOutput("bpKeep", {60'd0, m_keep}, 64'hF);
        checkOutput("bpRdEnLow", {63'd0, fifo_rd_en}, 64'd0);
        checkOutput("bpByteLeft", 64'(wrPtr - rdPtr), 64'd1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("bpHoldData", {32'd0, m_data}, 64'h14131211);
            tick(1);
        end
        m_ready = 1'b1;
        waitFifoEmpty("bpFifoDrain");
        tick(3);
        pulseFlush();
        waitIdle("bpIdle");

        // Partial flush of two bytes.
        applyStimulus(8'hAA);
        applyStimulus(8'hBB);
        pushExp(32'h0000BBAA, 4'h3, 1'b1);
        waitFifoEmpty("partFifoDrain");
        tick(3);
        pulseFlush();
        waitIdle("partIdle");

        // Empty flush: no beat, back in FILL two cycles later.
        pulseFlush();
        checkOutput("emptyNoBeat0", {63'd0, m_valid}, 64'd0);
        tick(1);
        checkOutput("emptyNoBeat1", {63'd0, m_valid}, 64'd0);
        applyStimulus(8'hCC);
        #1;
        checkOutput("emptyBackToFill", {63'd0, fifo_rd_en}, 64'd1);
        pushExp(32'h000000CC, 4'h1, 1'b1);
        tick(3);
        pulseFlush();
        waitIdle("ccIdle");

        // Flush in the cycle after the fourth read strobe.
        for (int i = 1; i <= 4; i++) applyStimulus(8'(8'h40 + i));
        pushExp(32'h44434241, 4'hF, 1'b1);
        #1;
        n = 0;
        for (int k = 0; k < 50 && n < 4; k++) begin
            if (fifo_rd_en && fifo_rd_valid) n++;
            if (n < 4) tick(1);
        end
        checkOutput("raceReads", 64'(n), 64'd4);
        tick(1);
        pulseFlush();
        waitIdle("raceIdle");

        // Reset after three captured bytes; they must vanish.
        for (int i = 1; i <= 3; i++) applyStimulus(8'(8'h50 + i));
        waitFifoEmpty("rstFifoDrain");
        tick(3);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstValid", {63'd0, m_valid}, 64'd0);
        checkOutput("midRstData", {32'd0, m_data}, 64'd0);
        checkOutput("midRstKeep", {60'd0, m_keep}, 64'd0);
        checkOutput("midRstLast", {63'd0, m_last}, 64'd0);
        checkOutput("midRstRdEn", {63'd0, fifo_rd_en}, 64'd0);
        tick(2);
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) applyStimulus(8'(8'h60 + i));
        pushExp(32'h64636261, 4'hF, 1'b0);
        waitIdle("postRstIdle");

        checkOutput("scoreboardEmpty", 64'(expQ.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
